// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, transmitter
// state encoding and the frame-length helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    // Total bit periods in one frame: start + payload + optional parity + stops.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side handshake of the UART transmitter: en/data in, busy/done back,
// plus the serial line itself.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 en;
    logic [DATA_BITS-1:0] data;
    logic                 busy;
    logic                 done;
    logic                 uart_tx;

    modport master (
        output en,
        output data,
        input  busy,
        input  done,
        input  uart_tx
    );

    modport slave (
        input  en,
        input  data,
        output busy,
        output done,
        output uart_tx
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 and flags the last clock of each
// period. Shared with the receiver, which uses clear to phase-align on a start edge.
module uart_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if (CLK_DIV < 2) begin : g_bad_div
        $error("uart_baud_tick: CLK_DIV must be >= 2");
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter on the system clock: start, DATA_BITS LSB-first,
// optional parity, STOP_BITS stops, with an en/busy handshake and a done pulse.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_cfg_if.slave   tx_if
);
    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_q;
    logic [3:0]           bit_cnt_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    logic accept;
    logic tick;
    logic par_d;

    assign accept = (state_q == IDLE) && tx_if.en;
    assign par_d  = (PARITY == PARITY_EVEN) ? (^tx_if.data) : ~(^tx_if.data);

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_if.en) begin
                        shreg_q   <= tx_if.data;
                        par_q     <= par_d;
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q      <= shreg_q[0];
                        shreg_q   <= shreg_q >> 1;
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            if (PARITY != PARITY_NONE) begin
                                tx_q    <= par_q;
                                state_q <= PAR;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            tx_q      <= shreg_q[0];
                            shreg_q   <= shreg_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                PAR: begin
                    if (tick) begin
                        tx_q      <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    // bit_cnt_q is reused to count stop bits
                    if (tick) begin
                        if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_if.busy    = busy_q;
    assign tx_if.done    = done_q;
    assign tx_if.uart_tx = tx_q;

    if (CLK_DIV < 2) begin : g_bad_div
        $error("uart_tx_cfg: CLK_DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: five instances covering 8N1, even/odd parity,
// 5-bit two-stop and 9-bit odd-parity frames at CLK_DIV=4.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] en_v;
    logic [8:0] data_v [5];
    wire  [4:0] tx_v, busy_v, done_v;

    uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if_b ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if_c ();
    uart_tx_cfg_if #(.DATA_BITS(5)) if_d ();
    uart_tx_cfg_if #(.DATA_BITS(9)) if_e ();

    assign if_a.en = en_v[0]; assign if_a.data = data_v[0][7:0];
    assign if_b.en = en_v[1]; assign if_b.data = data_v[1][7:0];
    assign if_c.en = en_v[2]; assign if_c.data = data_v[2][7:0];
    assign if_d.en = en_v[3]; assign if_d.data = data_v[3][4:0];
    assign if_e.en = en_v[4]; assign if_e.data = data_v[4];

    assign tx_v   = {if_e.uart_tx, if_d.uart_tx, if_c.uart_tx, if_b.uart_tx, if_a.uart_tx};
    assign busy_v = {if_e.busy, if_d.busy, if_c.busy, if_b.busy, if_a.busy};
    assign done_v = {if_e.done, if_d.done, if_c.done, if_b.done, if_a.done};

    uart_tx_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_a (.clk(clk), .rst_n(rst_n), .tx_if(if_a));
    uart_tx_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u_b (.clk(clk), .rst_n(rst_n), .tx_if(if_b));
    uart_tx_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        u_c (.clk(clk), .rst_n(rst_n), .tx_if(if_c));
    uart_tx_cfg #(.CLK_DIV(DIV), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2))
        u_d (.clk(clk), .rst_n(rst_n), .tx_if(if_d));
    uart_tx_cfg #(.CLK_DIV(DIV), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1))
        u_e (.clk(clk), .rst_n(rst_n), .tx_if(if_e));

    // Accept edge is E0; returns at E0+1 (cycle 1 of the frame).
    task automatic start_frame(input int k, input logic [8:0] d, input bit hold);
        @(negedge clk);
        en_v[k]   = 1'b1;
        data_v[k] = d;
        @(posedge clk);
        #1;
        if (!hold) en_v[k] = 1'b0;
    endtask

    // Samples cycles 1..nbits*DIV+1 after the accept edge; bit b is recorded on
    // its first and last clock. Unused positions stay 1. Returns at cycle nbits*DIV+2.
    task automatic capture(input int k, input int nbits,
                           output logic [15:0] first, output logic [15:0] last,
                           output int busy_cnt, output int done_at, output int done_cnt);
        first = '1; last = '1; busy_cnt = 0; done_at = -1; done_cnt = 0;
        for (int j = 1; j <= nbits * DIV + 1; j++) begin
            if ((j - 1) / DIV < nbits) begin
                if ((j - 1) % DIV == 0)       first[(j - 1) / DIV] = tx_v[k];
                if ((j - 1) % DIV == DIV - 1) last[(j - 1) / DIV]  = tx_v[k];
            end
            if (busy_v[k]) busy_cnt++;
            if (done_v[k]) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        en_v = '0;
        for (int i = 0; i < 5; i++) data_v[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks += 3;
            if (tx_v[i] !== 1'b1)   begin n_fail++; $display("FAIL reset_tx[%0d] got %b want 1", i, tx_v[i]); end
            if (busy_v[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", i, busy_v[i]); end
            if (done_v[i] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d] got %b want 0", i, done_v[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // Five checks on one captured frame against hand-computed values.
    task automatic test_frame(input string name, input int k, input logic [8:0] d,
                              input int nbits, input logic [15:0] exp_bits);
        logic [15:0] f, l;
        int bc, da, dc;
        start_frame(k, d, 1'b0);
        capture(k, nbits, f, l, bc, da, dc);
        n_checks += 5;
        if (f !== exp_bits) begin n_fail++; $display("FAIL %s bits_first got %h want %h", name, f, exp_bits); end
        if (l !== exp_bits) begin n_fail++; $display("FAIL %s bits_last got %h want %h", name, l, exp_bits); end
        if (bc !== nbits * DIV) begin n_fail++; $display("FAIL %s busy_cycles got %0d want %0d", name, bc, nbits * DIV); end
        if (da !== nbits * DIV + 1) begin n_fail++; $display("FAIL %s done_cycle got %0d want %0d", name, da, nbits * DIV + 1); end
        if (dc !== 1) begin n_fail++; $display("FAIL %s done_pulses got %0d want 1", name, dc); end
    endtask

    task automatic test_basic();
        test_frame("8n1_a5", 0, 9'h0A5, 10, 16'hFF4A);
    endtask

    task automatic test_parity();
        n_checks++;
        if (frame_bits(8, PARITY_EVEN, 1) !== 11) begin n_fail++; $display("FAIL frame_bits_8e1 got %0d want 11", frame_bits(8, PARITY_EVEN, 1)); end
        test_frame("8e1_07", 1, 9'h007, 11, 16'hFE0E);
        test_frame("8o1_07", 2, 9'h007, 11, 16'hFC0E);
    endtask

    task automatic test_two_stop();
        test_frame("5n2_1f", 3, 9'h01F, 8, 16'hFFFE);
    endtask

    task automatic test_nine_bits();
        test_frame("9o1_1ff", 4, 9'h1FF, frame_bits(9, PARITY_ODD, 1), 16'hFBFE);
    endtask

    task automatic test_back_to_back();
        logic [15:0] f1, l1, f2, l2;
        int bc1, da1, dc1, bc2, da2, dc2;
        start_frame(0, 9'h055, 1'b1);
        data_v[0] = 9'h0AA;
        capture(0, 10, f1, l1, bc1, da1, dc1);
        // Frame 2 was accepted on the edge closing the done cycle.
        en_v[0] = 1'b0;
        capture(0, 10, f2, l2, bc2, da2, dc2);
        n_checks += 6;
        if (f1 !== 16'hFEAA) begin n_fail++; $display("FAIL b2b_frame1 got %h want FEAA", f1); end
        if (l2 !== 16'hFF54) begin n_fail++; $display("FAIL b2b_frame2 got %h want FF54", l2); end
        if (f2 !== 16'hFF54) begin n_fail++; $display("FAIL b2b_frame2_first got %h want FF54", f2); end
        if (da1 !== 41) begin n_fail++; $display("FAIL b2b_done1 got %0d want 41", da1); end
        if (da2 !== 41) begin n_fail++; $display("FAIL b2b_done_spacing got %0d want 41", da2); end
        if (bc2 !== 40) begin n_fail++; $display("FAIL b2b_busy2 got %0d want 40", bc2); end
    endtask

    task automatic test_ignore_en();
        logic [15:0] f, l;
        int bc, da, dc, extra_busy;
        start_frame(0, 9'h0C3, 1'b0);
        fork
            capture(0, 10, f, l, bc, da, dc);
            begin
                repeat (3) begin
                    repeat (7) @(posedge clk);
                    #2;
                    en_v[0] = 1'b1;
                    data_v[0] = 9'h0FF;
                    @(posedge clk);
                    #2;
                    en_v[0] = 1'b0;
                end
            end
        join
        extra_busy = 0;
        repeat (8) begin
            if (busy_v[0] || done_v[0]) extra_busy++;
            @(posedge clk);
            #1;
        end
        n_checks += 4;
        if (l !== 16'hFF86) begin n_fail++; $display("FAIL ignore_en_frame got %h want FF86", l); end
        if (bc !== 40) begin n_fail++; $display("FAIL ignore_en_busy got %0d want 40", bc); end
        if (dc !== 1) begin n_fail++; $display("FAIL ignore_en_done got %0d want 1", dc); end
        if (extra_busy !== 0) begin n_fail++; $display("FAIL ignore_en_extra_frame got %0d want 0", extra_busy); end
    endtask

    task automatic test_async_reset();
        int done_seen;
        start_frame(0, 9'h000, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        n_checks += 2;
        if (tx_v[0] !== 1'b0)   begin n_fail++; $display("FAIL abort_pre_tx got %b want 0", tx_v[0]); end
        if (busy_v[0] !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy got %b want 1", busy_v[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (tx_v[0] !== 1'b1)   begin n_fail++; $display("FAIL abort_tx got %b want 1", tx_v[0]); end
        if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy_v[0]); end
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_v[0]) done_seen++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done_v[0]) done_seen++;
        end
        n_checks++;
        if (done_seen !== 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", done_seen); end
        test_frame("after_abort_3c", 0, 9'h03C, 10, 16'hFE78);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_nine_bits();
        test_back_to_back();
        test_ignore_en();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
